// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, MTHI/MTLO writes and MFHI/MFLO read port.
// Results land in HI/LO when the execute counter expires; done pulses for the cycle that follows.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  mdu_type,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_b, quot_u, rem_u;
  logic signed [31:0] quot_s, rem_s;
  logic               div_ovf;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  // A zero divisor is steered to 1 so the divider stays defined; that result is never written.
  assign div_b   = (b_q == 32'd0) ? 32'd1 : b_q;
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign quot_s  = $signed(a_q) / $signed(div_b);
  assign rem_s   = $signed(a_q) % $signed(div_b);
  assign quot_u  = a_q / div_b;
  assign rem_u   = a_q % div_b;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path through the cases infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        case (mdu_type)
          OP_MULT, OP_MULTU: begin
            state_d = S_EXEC;
            cnt_d   = MULT_LOAD;
            op_d    = mdu_type;
            a_d     = src_a;
            b_d     = src_b;
          end
          OP_DIV, OP_DIVU: begin
            state_d = S_EXEC;
            cnt_d   = DIV_LOAD;
            op_d    = mdu_type;
            a_d     = src_a;
            b_d     = src_b;
          end
          OP_MTHI: hi_d = src_a;
          OP_MTLO: lo_d = src_a;
          default: ;
        endcase
      end
    end else begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_MULT:  {hi_d, lo_d} = prod_s;
          OP_MULTU: {hi_d, lo_d} = prod_u;
          OP_DIV: begin
            if (div_ovf) begin
              hi_d = 32'd0;
              lo_d = 32'h8000_0000;
            end else if (b_q != 32'd0) begin
              hi_d = rem_s;
              lo_d = quot_s;
            end
          end
          OP_DIVU: begin
            if (b_q != 32'd0) begin
              hi_d = rem_u;
              lo_d = quot_u;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // NOTE: operand/opcode latches carry no reset; they are only read in EXEC, which always loads them first.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  assign busy    = (state_q == S_EXEC);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mf_data = (mdu_type == OP_MFHI) ? hi_q :
                   (mdu_type == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model of HI/LO.
module tb_mul_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdu_type = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo, mf_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;
  logic [31:0] pend_hi = 32'd0, pend_lo = 32'd0;
  int pend_cycles = 0;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mdu_type(mdu_type),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  // Reference: {hi,lo} after the op, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] h, input logic [31:0] l);
    longint sa, sb, ua, ub, p, q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      4'd1: begin p = sa * sb; return p; end
      4'd2: begin p = ua * ub; return p; end
      4'd3: begin
        if (b == 32'd0) return {h, l};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {h, l};
        q = ua / ub; r = ua % ub;
        return {r[31:0], q[31:0]};
      end
      default: return {h, l};
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; start = 1'b1; mdu_type = 4'd7; src_a = $urandom;
    tick; tick;
    reset_n = 1'b1; start = 1'b0; mdu_type = 4'd0;
    exp_hi = 32'd0; exp_lo = 32'd0;
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu_type = op; src_a = a; src_b = b; start = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL accept_busy: busy=%0b required 0", busy);
    end
    {pend_hi, pend_lo} = model(op, a, b, exp_hi, exp_lo);
    pend_cycles = (op == 4'd1 || op == 4'd2) ? MC : DC;
    tick;
    start = 1'b0; mdu_type = 4'd0; src_a = $urandom; src_b = $urandom;
  endtask

  // Counts the remaining busy window and leaves time in the done cycle.
  task automatic finish_op(input int want);
    int n = 0;
    while (busy === 1'b1 && n < 60) begin
      checks++;
      if (done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        failures++;
        $display("FAIL busy_hold: done=%0b hi=%h lo=%h required done=0 hi=%h lo=%h", done, hi, lo, exp_hi, exp_lo);
      end
      src_a = $urandom; src_b = $urandom;
      n++;
      tick;
    end
    checks++;
    if (n !== want) begin
      failures++; $display("FAIL busy_len: got %0d cycles required %0d", n, want);
    end
    exp_hi = pend_hi; exp_lo = pend_lo;
    checks++;
    if (done !== 1'b1) begin
      failures++; $display("FAIL done_pulse: done=%0b required 1", done);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      failures++; $display("FAIL result: hi=%h lo=%h required hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
    end
    mdu_type = 4'd5; #1;
    checks++;
    if (mf_data !== exp_hi) begin
      failures++; $display("FAIL mfhi_on_done: mf_data=%h required %h", mf_data, exp_hi);
    end
    mdu_type = 4'd6; #1;
    checks++;
    if (mf_data !== exp_lo) begin
      failures++; $display("FAIL mflo_on_done: mf_data=%h required %h", mf_data, exp_lo);
    end
    mdu_type = 4'd0;
  endtask

  task automatic after_done;
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL done_once: done=%0b busy=%0b required 0 0", done, busy);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start_op(op, a, b);
    finish_op(pend_cycles);
    after_done;
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
    mdu_type = op; src_a = a; start = 1'b1;
    tick;
    start = 1'b0; mdu_type = 4'd0;
    if (op == 4'd7) exp_hi = a; else exp_lo = a;
    checks++;
    if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mt_write: hi=%h lo=%h busy=%0b done=%0b required hi=%h lo=%h 0 0", hi, lo, busy, done, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL reset_state: busy=%0b done=%0b hi=%h lo=%h required all 0", busy, done, hi, lo);
    end
    // Start in the very first cycle out of reset.
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      failures++; $display("FAIL mult_neg: hi=%h lo=%h required ffffffff fffffffa", hi, lo);
    end
  endtask

  task automatic test_directed;
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      failures++; $display("FAIL multu_max: hi=%h lo=%h required fffffffe 00000001", hi, lo);
    end
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL div_neg: hi=%h lo=%h required ffffffff fffffffd", hi, lo);
    end
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      failures++; $display("FAIL div_ovf: hi=%h lo=%h required 00000000 80000000", hi, lo);
    end
    do_mt(4'd7, 32'h1234);
    do_mt(4'd8, 32'h5678);
    run_op(4'd4, 32'd7, 32'd0);
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      failures++; $display("FAIL divu_zero: hi=%h lo=%h required 00001234 00005678", hi, lo);
    end
    run_op(4'd3, 32'd100, 32'd0);
  endtask

  task automatic test_mf;
    do_mt(4'd8, 32'h0000_BEEF);
    mdu_type = 4'd6; #1;
    checks++;
    if (mf_data !== 32'h0000_BEEF || busy !== 1'b0) begin
      failures++; $display("FAIL mflo_read: mf_data=%h busy=%0b required 0000beef 0", mf_data, busy);
    end
    mdu_type = 4'd3; #1;
    checks++;
    if (mf_data !== 32'd0) begin
      failures++; $display("FAIL mf_other: mf_data=%h required 0", mf_data);
    end
    mdu_type = 4'd0;
  endtask

  task automatic test_start_ignored;
    start_op(4'd1, 32'd1000, 32'd7);
    tick;
    start = 1'b1; mdu_type = 4'd7; src_a = 32'h0000_AAAA;
    tick;
    mdu_type = 4'd3; src_a = 32'd9; src_b = 32'd2;
    tick;
    start = 1'b0; mdu_type = 4'd0;
    finish_op(MC - 3);
    after_done;
  endtask

  task automatic test_noop;
    logic [3:0] ops [0:3];
    ops[0] = 4'd0; ops[1] = 4'd5; ops[2] = 4'd6; ops[3] = 4'($urandom_range(9, 15));
    for (int i = 0; i < 4; i++) begin
      mdu_type = ops[i]; src_a = $urandom; src_b = $urandom; start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        failures++;
        $display("FAIL noop_%0d: busy=%0b done=%0b hi=%h lo=%h required 0 0 %h %h", ops[i], busy, done, hi, lo, exp_hi, exp_lo);
      end
    end
    mdu_type = 4'd0;
  endtask

  task automatic test_back_to_back;
    start_op(4'd1, $urandom, $urandom);
    finish_op(MC);
    start_op(4'd3, $urandom, 32'd0 - 32'd5);
    finish_op(DC);
    start_op(4'd2, $urandom, $urandom);
    finish_op(MC);
    start_op(4'd4, $urandom, 32'd0);
    finish_op(DC);
    after_done;
  endtask

  task automatic test_reset_during_exec;
    bit saw_done = 1'b0;
    start_op(4'd4, 32'd5000, 32'd3);
    tick; tick; tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL reset_exec: busy=%0b hi=%h lo=%h required 0 0 0", busy, hi, lo);
    end
    for (int i = 0; i < DC + 2; i++) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++; $display("FAIL reset_no_done: saw done=1 required none");
    end
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 8));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if (op >= 4'd7) do_mt(op, a);
      else if (op >= 4'd5) test_noop;
      else run_op(op, a, b);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_mf;
    test_start_ignored;
    test_noop;
    test_back_to_back;
    test_reset_during_exec;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, execute cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, execute cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port start  input  1  operation request, qualified by mdu_type.
REQ-006 SHALL have port mdu_type  input  4  op code: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 none.
REQ-007 SHALL have port src_a  input  32  rs operand.
REQ-008 SHALL have port src_b  input  32  rt operand.
REQ-009 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse after HI/LO update from MULT/MULTU/DIV/DIVU.
REQ-011 SHALL have port hi  output  32  HI register.
REQ-012 SHALL have port lo  output  32  LO register.
REQ-013 SHALL have port mf_data  output  32  combinational: hi when mdu_type=5, lo when 6, else 0.

Function
REQ-014 SHALL implement two states: IDLE and EXEC.
REQ-015 SHALL, in IDLE, with start=1 and mdu_type 1-4, latch src_a, src_b and mdu_type, load the cycle counter with MULT_CYCLES (1,2) or DIV_CYCLES (3,4), and enter EXEC at that edge.
REQ-016 SHALL assert busy for exactly the configured count of cycles starting the cycle after the accepting edge; busy=0 in the accepting cycle itself.
REQ-017 SHALL decrement the counter once per cycle in EXEC; at the edge where the counter goes from 1 to 0, SHALL write the result to hi/lo, return to IDLE, and assert done for the following cycle only.
REQ-018 SHALL compute results from latched operands only; src_a/src_b changes during EXEC SHALL have no effect.
REQ-019 SHALL implement MULT as a signed 32x32 multiply to 64 bits with {hi,lo} = product; MULTU likewise, unsigned.
REQ-020 SHALL implement DIV as signed division with lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign; DIVU likewise, unsigned.
REQ-021 SHALL, for DIV with 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0.
REQ-022 SHALL, for DIV/DIVU with divisor 0, still run DIV_CYCLES cycles and pulse done, but leave hi and lo unchanged.
REQ-023 SHALL, in IDLE, with start=1 and mdu_type 7 (MTHI), write src_a to hi at that edge; with mdu_type 8 (MTLO), write src_a to lo; busy stays 0, no done.
REQ-024 SHALL ignore start (any mdu_type) while in EXEC; no state, counter or hi/lo change.
REQ-025 SHALL treat start with mdu_type 0, 5, 6 or 9-15 as a no-op for state and hi/lo.
REQ-026 SHALL allow a new start to be accepted in the cycle done is high; back-to-back operations SHALL each produce their own full busy window.
REQ-027 SHALL, when mf_data is sampled in the cycle done is high, return the newly written value.

Reset
REQ-028 SHALL, on a rising clk with reset_n=0, force state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, regardless of start.
REQ-029 SHALL, on reset during EXEC, discard the in-flight result; hi/lo read 0 after reset.
REQ-030 SHALL accept a start in the first cycle with reset_n=1.

Verification
REQ-031 MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
REQ-032 MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 after MTHI 0x1234 and MTLO 0x5678 -> hi=0x1234, lo=0x5678 after 10 cycles.
REQ-034 MULT accepted, then start with MTHI 0xAAAA on busy cycle 2 -> ignored; hi holds the MULT result on completion.
REQ-035 DIVU started, reset_n=0 on busy cycle 4 -> next cycle busy=0, hi=lo=0, done never pulses.
REQ-036 MTLO 0x0000BEEF then mdu_type=6 -> mf_data=0x0000BEEF in the next cycle, busy stays 0.
